log_capture_ctrl: RTL and testbench



---
 rtl/log_pkg.sv | 13 +
 rtl/log_capture_ctrl_if.sv | 27 ++
 rtl/log_bram.sv | 33 +++
 rtl/log_capture_ctrl.sv | 92 +++++++++
 tb/tb_log_capture_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared types and default sizes for the DSP sample log
package log_pkg;

   localparam int LOG_NB_DATA = 64;
   localparam int LOG_NB_ADDR = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FULL    = 2'd2
   } log_state_t;

endpackage

// File: rtl/log_capture_ctrl_if.sv
// rtl/log_capture_ctrl_if.sv - register file / DSP side signals of the log sequencer
interface log_capture_ctrl_if import log_pkg::*; #(
   parameter int NB_DATA = LOG_NB_DATA,
   parameter int NB_ADDR = LOG_NB_ADDR
) ();

   logic               i_run_log;
   logic               i_read_log;
   logic [NB_ADDR-1:0] i_addr_log;
   logic [NB_DATA-1:0] i_data;
   logic               i_valid;
   logic [NB_DATA-1:0] o_data_log;
   logic               o_mem_full;
   logic               o_busy;
   logic [NB_ADDR:0]   o_log_count;

   modport master (
      output i_run_log, i_read_log, i_addr_log, i_data, i_valid,
      input  o_data_log, o_mem_full, o_busy, o_log_count
   );

   modport slave (
      input  i_run_log, i_read_log, i_addr_log, i_data, i_valid,
      output o_data_log, o_mem_full, o_busy, o_log_count
   );

endinterface

// File: rtl/log_bram.sv
// rtl/log_bram.sv - simple dual-port log memory with a registered read port
module log_bram #(
   parameter int NB_DATA = 64,
   parameter int NB_ADDR = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [NB_ADDR-1:0] waddr,
   input  logic [NB_DATA-1:0] wdata,
   input  logic               re,
   input  logic [NB_ADDR-1:0] raddr,
   output logic [NB_DATA-1:0] rdata
);

   logic [NB_DATA-1:0] mem [2**NB_ADDR];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the output register is reset; the array stays inferable as block RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/log_capture_ctrl.sv
// rtl/log_capture_ctrl.sv - arms on a run edge, fills the log once, then serves readout
module log_capture_ctrl import log_pkg::*; #(
   parameter int NB_DATA = LOG_NB_DATA,
   parameter int NB_ADDR = LOG_NB_ADDR
) (
   input  logic              clk,
   input  logic              i_rst,
   log_capture_ctrl_if.slave bus
);

   localparam logic [NB_ADDR:0]   DEPTH     = {1'b1, {NB_ADDR{1'b0}}};
   localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

   log_state_t         state;
   logic               run_d;
   logic               run_hold;
   logic [NB_ADDR-1:0] wr_addr;
   logic [NB_ADDR:0]   log_count;
   logic               mem_full;
   logic               busy;
   logic               run_start;
   logic               we;
   logic               re;

   // run_hold masks a run level carried through reset until it has been seen low.
   assign run_start = bus.i_run_log & ~run_d & ~run_hold;
   assign we        = (state == CAPTURE) & bus.i_valid;
   assign re        = bus.i_read_log & (state != CAPTURE);

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state     <= IDLE;
         run_d     <= 1'b0;
         run_hold  <= bus.i_run_log;
         wr_addr   <= '0;
         log_count <= '0;
         mem_full  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         run_d <= bus.i_run_log;
         if (!bus.i_run_log) begin
            run_hold <= 1'b0;
         end
         case (state)
            IDLE, FULL: begin
               if (run_start) begin
                  state     <= CAPTURE;
                  wr_addr   <= '0;
                  log_count <= '0;
                  mem_full  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            CAPTURE: begin
               if (we) begin
                  if (log_count != DEPTH) begin
                     log_count <= log_count + 1'b1;
                  end
                  // The last slot ends the capture; wr_addr parks instead of wrapping.
                  if (wr_addr == LAST_ADDR) begin
                     state    <= FULL;
                     mem_full <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   log_bram #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_bram (
      .clk   (clk),
      .rst   (i_rst),
      .we    (we),
      .waddr (wr_addr),
      .wdata (bus.i_data),
      .re    (re),
      .raddr (bus.i_addr_log),
      .rdata (bus.o_data_log)
   );

   assign bus.o_mem_full  = mem_full;
   assign bus.o_busy      = busy;
   assign bus.o_log_count = log_count;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// tb/tb_log_capture_ctrl.sv - directed bench for log_capture_ctrl at depth 16
module tb_log_capture_ctrl;

   logic clk = 1'b0;
   logic i_rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   log_capture_ctrl_if #(.NB_DATA(64), .NB_ADDR(4)) bus ();

   log_capture_ctrl #(.NB_DATA(64), .NB_ADDR(4)) dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      i_rst          = 1'b1;
      bus.i_run_log  = 1'b1;
      bus.i_read_log = 1'b0;
      bus.i_addr_log = '0;
      bus.i_data     = '0;
      bus.i_valid    = 1'b0;

      // 1: run held high through reset must not start a capture
      tick; tick; tick;
      i_rst       = 1'b0;
      bus.i_valid = 1'b1;
      tick; tick; tick;
      check("rst_busy",  bus.o_busy,      0);
      check("rst_full",  bus.o_mem_full,  0);
      check("rst_count", bus.o_log_count, 0);
      check("rst_data",  bus.o_data_log,  0);
      bus.i_valid   = 1'b0;
      bus.i_run_log = 1'b0;
      tick;
      check("idle_busy", bus.o_busy, 0);

      // 2: full capture of 16 back-to-back samples
      bus.i_run_log = 1'b1;
      tick;
      check("arm_busy",  bus.o_busy,      1);
      check("arm_count", bus.o_log_count, 0);
      for (int i = 0; i < 16; i++) begin
         bus.i_valid = 1'b1;
         bus.i_data  = 64'h100 + 64'(i);
         tick;
         check($sformatf("cap_count%0d", i), bus.o_log_count, 64'(i + 1));
         check($sformatf("cap_busy%0d", i),  bus.o_busy,      (i < 15) ? 64'd1 : 64'd0);
         check($sformatf("cap_full%0d", i),  bus.o_mem_full,  (i == 15) ? 64'd1 : 64'd0);
      end
      bus.i_valid = 1'b0;

      // 3: readout sweep, one cycle latency
      bus.i_read_log = 1'b1;
      for (int a = 0; a < 16; a++) begin
         bus.i_addr_log = 4'(a);
         tick;
         check($sformatf("rd1_%0d", a), bus.o_data_log, 64'h100 + 64'(a));
      end
      bus.i_read_log = 1'b0;

      // 4: gapped writes, run dropped and re-raised mid-capture
      bus.i_run_log = 1'b0;
      tick;
      bus.i_run_log = 1'b1;
      tick;
      check("gap_arm", bus.o_busy, 1);
      for (int j = 0; j < 16; j++) begin
         bus.i_valid = 1'b1;
         bus.i_data  = 64'h200 + 64'(j);
         if (j == 5) bus.i_run_log = 1'b0;
         if (j == 6) bus.i_run_log = 1'b1;
         tick;
         bus.i_valid = 1'b0;
         check($sformatf("gap_count%0d", j), bus.o_log_count, 64'(j + 1));
         check($sformatf("gap_full%0d", j),  bus.o_mem_full,  (j == 15) ? 64'd1 : 64'd0);
         tick; tick;
      end
      bus.i_read_log = 1'b1;
      for (int a = 0; a < 16; a++) begin
         bus.i_addr_log = 4'(a);
         tick;
         check($sformatf("rd2_%0d", a), bus.o_data_log, 64'h200 + 64'(a));
      end

      // 5: same-cycle run and read in FULL, then output frozen during capture
      bus.i_read_log = 1'b0;
      bus.i_run_log  = 1'b0;
      tick;
      check("pre_hold", bus.o_data_log, 64'h20F);
      bus.i_run_log  = 1'b1;
      bus.i_read_log = 1'b1;
      bus.i_addr_log = 4'd3;
      tick;
      check("race_data", bus.o_data_log, 64'h203);
      check("race_busy", bus.o_busy,     1);
      bus.i_addr_log = 4'd5;
      tick;
      check("frz_idle", bus.o_data_log, 64'h203);
      for (int j = 0; j < 7; j++) begin
         bus.i_valid    = 1'b1;
         bus.i_data     = 64'h300 + 64'(j);
         bus.i_addr_log = 4'(j);
         tick;
         check($sformatf("frz_data%0d", j),  bus.o_data_log,  64'h203);
         check($sformatf("frz_count%0d", j), bus.o_log_count, 64'(j + 1));
      end
      bus.i_valid = 1'b0;

      // 6: reset mid-capture, then a new capture overwrites from address 0
      i_rst = 1'b1;
      tick; tick;
      i_rst = 1'b0;
      check("ab_busy",  bus.o_busy,      0);
      check("ab_count", bus.o_log_count, 0);
      check("ab_full",  bus.o_mem_full,  0);
      check("ab_data",  bus.o_data_log,  0);
      bus.i_valid = 1'b1;
      tick; tick;
      check("ab_nostart", bus.o_busy,      0);
      check("ab_nocount", bus.o_log_count, 0);
      bus.i_valid    = 1'b0;
      bus.i_read_log = 1'b0;
      bus.i_run_log  = 1'b0;
      tick;
      bus.i_run_log = 1'b1;
      tick;
      check("re_arm", bus.o_busy, 1);
      for (int j = 0; j < 16; j++) begin
         bus.i_valid = 1'b1;
         bus.i_data  = 64'h400 + 64'(j);
         tick;
      end
      bus.i_valid = 1'b0;
      check("re_count", bus.o_log_count, 16);
      check("re_full",  bus.o_mem_full,  1);
      bus.i_read_log = 1'b1;
      for (int a = 0; a < 16; a++) begin
         bus.i_addr_log = 4'(a);
         tick;
         check($sformatf("rd3_%0d", a), bus.o_data_log, 64'h400 + 64'(a));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
